// File: rtl/serial_pkg.sv
// Shared types and constants for the serial slave: byte width, bit counter
// width, frame state encoding and a small shift helper.
package serial_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BITCNT_W = 3;

  typedef logic [BYTE_W-1:0]   byte_t;
  typedef logic [BITCNT_W-1:0] bitcnt_t;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

  // MSB-first serial shift: new bit enters at the LSB.
  function automatic byte_t shift_in(input byte_t cur, input logic b);
    return {cur[BYTE_W-2:0], b};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// N-flop synchronizer for an asynchronous input, followed by one history flop
// that turns the synchronized level into single-cycle rise/fall strobes.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = level;
  end

  // Reset to the pin's idle level so a released reset never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/serial_slave.sv
// Byte-oriented serial slave: samples SI on FCK rise, launches SO on FCK fall,
// frames delimited by CSN, all serial pins oversampled in the CLK domain.
module serial_slave import serial_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              FCK,
  input  logic              CSN,
  input  logic              SI,
  output logic              SO,
  output logic              SOE,
  input  logic [BYTE_W-1:0] TXDATA,
  output logic              TXREQ,
  output logic [BYTE_W-1:0] RXDATA,
  output logic              RXSTB,
  output logic              BUSY,
  output logic              ABORT
);

  logic fck_rise, fck_fall;
  logic csn_rise, csn_fall;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_fck_sync (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .async_i(FCK),
    .rise_o (fck_rise),
    .fall_o (fck_fall)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_csn_sync (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .async_i(CSN),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  // SI uses the same depth as FCK so data lines up with the detected rise.
  logic [SYNC_STAGES-1:0] si_q, si_d;
  logic                   si_s;

  assign si_s = si_q[SYNC_STAGES-1];

  state_e  state_q, state_d;
  bitcnt_t bitcnt_q, bitcnt_d;
  byte_t   tx_sh_q, tx_sh_d;
  byte_t   rx_sh_q, rx_sh_d;
  byte_t   rxdata_q, rxdata_d;
  logic    rxstb_q, rxstb_d;
  logic    txreq_q, txreq_d;
  logic    abort_q, abort_d;

  always_comb begin
    si_d     = {si_q[SYNC_STAGES-2:0], SI};
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    rxdata_d = rxdata_q;
    rxstb_d  = 1'b0;
    txreq_d  = 1'b0;
    abort_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d  = StActive;
          bitcnt_d = '0;
          tx_sh_d  = '0;
          rx_sh_d  = '0;
        end
      end

      StActive: begin
        if (csn_rise) begin
          state_d  = StIdle;
          bitcnt_d = '0;
          abort_d  = (bitcnt_q != '0);
        end else begin
          // Fall at bit 0 launches a new byte; later falls expose the next bit.
          if (fck_fall) begin
            if (bitcnt_q == '0) begin
              tx_sh_d = TXDATA;
            end else begin
              tx_sh_d = {tx_sh_q[BYTE_W-2:0], 1'b0};
            end
          end
          if (fck_rise) begin
            rx_sh_d  = shift_in(rx_sh_q, si_s);
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == '1) begin
              rxdata_d = shift_in(rx_sh_q, si_s);
              rxstb_d  = 1'b1;
              txreq_d  = 1'b1;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      si_q     <= '0;
      state_q  <= StIdle;
      bitcnt_q <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      rxdata_q <= '0;
      rxstb_q  <= 1'b0;
      txreq_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      si_q     <= si_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      rxdata_q <= rxdata_d;
      rxstb_q  <= rxstb_d;
      txreq_q  <= txreq_d;
      abort_q  <= abort_d;
    end
  end

  assign BUSY   = (state_q == StActive);
  assign SOE    = BUSY;
  assign SO     = BUSY & tx_sh_q[BYTE_W-1];
  assign RXDATA = rxdata_q;
  assign RXSTB  = rxstb_q;
  assign TXREQ  = txreq_q;
  assign ABORT  = abort_q;

endmodule

// File: tb/tb_serial_slave.sv
// Self-checking bench for serial_slave: a master model drives FCK/CSN/SI at
// CLK/4, table vectors cover the directed cases, random frames use a byte-level model.
`timescale 1ns/100ps
module tb_serial_slave;

  logic       CLK = 1'b0;
  logic       RSTN, FCK, CSN, SI;
  logic       SO, SOE, TXREQ, RXSTB, BUSY, ABORT;
  logic [7:0] TXDATA, RXDATA;

  always #4 CLK = ~CLK;

  serial_slave #(.SYNC_STAGES(2)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .FCK   (FCK),
    .CSN   (CSN),
    .SI    (SI),
    .SO    (SO),
    .SOE   (SOE),
    .TXDATA(TXDATA),
    .TXREQ (TXREQ),
    .RXDATA(RXDATA),
    .RXSTB (RXSTB),
    .BUSY  (BUSY),
    .ABORT (ABORT)
  );

  int total = 0;
  int bad   = 0;

  // Monitor counters; only the monitor writes them, tests take differences.
  int         n_strb = 0, n_req = 0, n_abt = 0, n_soe_bad = 0, n_so_idle_bad = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  logic [7:0] mosi_q[$];
  logic       so_got[$];

  initial forever begin
    @(negedge CLK);
    if (RXSTB) begin
      n_strb++;
      rx_got.push_back(RXDATA);
    end
    if (TXREQ) n_req++;
    if (ABORT) n_abt++;
    if (SOE !== BUSY) n_soe_bad++;
    if (!BUSY && SO !== 1'b0) n_so_idle_bad++;
  end

  // User side: supply the next byte one CLK-fraction after TXREQ.
  initial forever begin
    @(posedge CLK);
    #1;
    if (TXREQ === 1'b1 && tx_q.size() != 0) TXDATA = tx_q.pop_front();
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Master: fall launches SI, rise is the slave's sample point, SO captured
  // at the end of the high phase (one full FCK period after the launch).
  task automatic send_bits(input int nbits, input real ph);
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] b;
      b   = mosi_q[i/8];
      FCK = 1'b0;
      SI  = b[7 - (i % 8)];
      #(ph);
      FCK = 1'b1;
      #(ph);
      so_got.push_back(SO);
    end
  endtask

  task automatic run_frame(input int nbits, input real ph, input real off);
    @(posedge CLK);
    #(off);
    CSN = 1'b0;
    #(32.0);
    send_bits(nbits, ph);
    CSN = 1'b1;
    SI  = 1'b0;
    #(48.0);
  endtask

  typedef struct {
    int          nbits;
    logic [23:0] mosi;
    logic [23:0] txd;
    int          nstrb;
    int          nabt;
    logic [23:0] exp_rx;
    logic [23:0] exp_so;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          b_s, b_r, b_a, b_rx;
    logic [23:0] mask, sw, tmp;

    vecs[0] = '{8,  24'h3C0000, 24'hA50000, 1, 0, 24'h3C0000, 24'hA50000};
    vecs[1] = '{24, 24'h0180FF, 24'hA51122, 3, 0, 24'h0180FF, 24'hA51122};
    vecs[2] = '{5,  24'hB00000, 24'hC30000, 0, 1, 24'h000000, 24'hC00000};
    vecs[3] = '{8,  24'h5A0000, 24'h3C0000, 1, 0, 24'h5A0000, 24'h3C0000};
    vecs[4] = '{16, 24'h00FF00, 24'hFF0000, 2, 0, 24'h00FF00, 24'hFF0000};
    vecs[5] = '{9,  24'hC38000, 24'h967E00, 1, 1, 24'hC30000, 24'h960000};

    RSTN = 1'b0; FCK = 1'b1; CSN = 1'b1; SI = 1'b0; TXDATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset SO", SO, 0);
    chk("reset SOE", SOE, 0);
    chk("reset BUSY", BUSY, 0);
    chk("reset RXDATA", RXDATA, 0);
    chk("reset pulses", {TXREQ, RXSTB, ABORT}, 0);
    #1 RSTN = 1'b1;
    repeat (4) @(posedge CLK);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      tx_q.delete();
      mosi_q.delete();
      so_got.delete();
      tmp    = vecs[v].txd;
      TXDATA = tmp[23:16];
      tx_q.push_back(tmp[15:8]);
      tx_q.push_back(tmp[7:0]);
      tmp = vecs[v].mosi;
      mosi_q.push_back(tmp[23:16]);
      mosi_q.push_back(tmp[15:8]);
      mosi_q.push_back(tmp[7:0]);
      b_s = n_strb; b_r = n_req; b_a = n_abt; b_rx = rx_got.size();
      run_frame(vecs[v].nbits, 16.0, 3.0);
      chk($sformatf("vec%0d rxstb", v), n_strb - b_s, vecs[v].nstrb);
      chk($sformatf("vec%0d txreq", v), n_req - b_r, vecs[v].nstrb);
      chk($sformatf("vec%0d abort", v), n_abt - b_a, vecs[v].nabt);
      tmp = vecs[v].exp_rx;
      for (int k = 0; k < vecs[v].nstrb; k++)
        chk($sformatf("vec%0d rx byte %0d", v, k), rx_got[b_rx + k], tmp[23 - 8*k -: 8]);
      sw = '0;
      for (int i = 0; i < vecs[v].nbits; i++) sw[23 - i] = so_got[i];
      mask = ~(24'hFFFFFF >> vecs[v].nbits);
      chk($sformatf("vec%0d so bits", v), sw & mask, vecs[v].exp_so & mask);
      chk($sformatf("vec%0d busy after", v), BUSY, 0);
    end
    tx_q.delete();

    // Idle noise: FCK toggling with CSN high must do nothing.
    b_s = n_strb; b_r = n_req; b_a = n_abt;
    @(posedge CLK);
    #2.5;
    for (int i = 0; i < 16; i++) begin
      FCK = ~FCK;
      SI  = 1'($urandom_range(0, 1));
      #16.0;
    end
    FCK = 1'b1;
    #48.0;
    chk("idle rxstb", n_strb - b_s, 0);
    chk("idle txreq", n_req - b_r, 0);
    chk("idle abort", n_abt - b_a, 0);
    chk("idle busy", BUSY, 0);

    // Reset in the middle of a byte.
    mosi_q.delete();
    mosi_q.push_back(8'h99);
    TXDATA = 8'hE7;
    b_a = n_abt;
    @(posedge CLK);
    #5.0;
    CSN = 1'b0;
    #32.0;
    send_bits(3, 16.0);
    RSTN = 1'b0;
    #1;
    chk("midrst SO", SO, 0);
    chk("midrst SOE", SOE, 0);
    chk("midrst BUSY", BUSY, 0);
    chk("midrst RXDATA", RXDATA, 0);
    chk("midrst pulses", {TXREQ, RXSTB, ABORT}, 0);
    CSN = 1'b1; FCK = 1'b1; SI = 1'b0;
    #24.0;
    RSTN = 1'b1;
    #40.0;
    chk("midrst no abort", n_abt - b_a, 0);
    mosi_q.delete();
    so_got.delete();
    mosi_q.push_back(8'h77);
    TXDATA = 8'h42;
    b_s = n_strb; b_rx = rx_got.size();
    run_frame(8, 16.0, 6.0);
    chk("post-rst rxstb", n_strb - b_s, 1);
    if (n_strb - b_s >= 1) chk("post-rst rx", rx_got[b_rx], 8'h77);
    sw = '0;
    for (int i = 0; i < 8; i++) sw[7 - i] = so_got[i];
    chk("post-rst so", sw[7:0], 8'h42);
    chk("post-rst abort", n_abt - b_a, 0);

    // Random frames, 2-CLK phases, random phase offset versus CLK.
    begin
      int         sent;
      int         nb, extra, nt;
      real        off;
      logic [7:0] txd[$];
      logic [7:0] sb;
      sent = 0;
      while (sent < 1000) begin
        nb = $urandom_range(1, 8);
        if (sent + nb > 1000) nb = 1000 - sent;
        extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        nt    = nb + ((extra != 0) ? 1 : 0);
        mosi_q.delete();
        so_got.delete();
        txd.delete();
        tx_q.delete();
        for (int k = 0; k < nt; k++) begin
          mosi_q.push_back(8'($urandom));
          txd.push_back(8'($urandom));
        end
        TXDATA = txd[0];
        for (int k = 1; k < nt; k++) tx_q.push_back(txd[k]);
        off = real'($urandom_range(1, 79)) / 10.0;
        b_s = n_strb; b_a = n_abt; b_rx = rx_got.size();
        run_frame(nb * 8 + extra, 16.0, off);
        chk("rand rxstb count", n_strb - b_s, nb);
        chk("rand abort count", n_abt - b_a, (extra != 0) ? 1 : 0);
        for (int k = 0; k < nb; k++) begin
          if (b_rx + k < rx_got.size())
            chk($sformatf("rand rx byte %0d", sent + k), rx_got[b_rx + k], mosi_q[k]);
          else
            chk($sformatf("rand rx byte %0d missing", sent + k), 32'hFFFF_FFFF, mosi_q[k]);
          for (int i = 0; i < 8; i++) sb[7 - i] = so_got[8*k + i];
          chk($sformatf("rand so byte %0d", sent + k), sb, txd[k]);
        end
        sent += nb;
      end
      tx_q.delete();
    end

    chk("SOE tracks BUSY", n_soe_bad, 0);
    chk("SO low when idle", n_so_idle_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_slave.md
SERIAL_SLAVE -- requirements
Module: serial_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on FCK, CSN and SI (legal range 2..3).
REQ-002 SHALL have port CLK, input, 1, system clock 125 MHz.
REQ-003 SHALL have port RSTN, input, 1, reset, asynchronous, active-low; one clock domain (CLK) only.
REQ-004 SHALL have port FCK, input, 1, serial clock from master, asynchronous to CLK, idles high.
REQ-005 SHALL have port CSN, input, 1, frame select from master, active-low.
REQ-006 SHALL have port SI, input, 1, serial data from master, MSB first.
REQ-007 SHALL have port SO, output, 1, serial data to master, MSB first.
REQ-008 SHALL have port SOE, output, 1, output enable for the SO pad buffer.
REQ-009 SHALL have port TXDATA, input, 8, next byte to send.
REQ-010 SHALL have port TXREQ, output, 1, one-CLK pulse requesting the next TXDATA.
REQ-011 SHALL have port RXDATA, output, 8, last complete received byte.
REQ-012 SHALL have port RXSTB, output, 1, one-CLK pulse, RXDATA valid.
REQ-013 SHALL have port BUSY, output, 1, frame active.
REQ-014 SHALL have port ABORT, output, 1, one-CLK pulse, frame ended mid-byte.

Function
REQ-015 SHALL pass FCK, CSN and SI through SYNC_STAGES flops; FCK edge detection SHALL use one further flop.
REQ-016 SHALL implement states IDLE (CSN high) and ACTIVE (CSN low); a synchronized CSN fall moves to ACTIVE with BITCNT=0; a CSN rise moves to IDLE.
REQ-017 In ACTIVE, a detected FCK fall with BITCNT=0 SHALL load TXDATA into the TX shift register (launch of bit 7); with BITCNT=1..7 it SHALL shift TX left by one.
REQ-018 In ACTIVE, a detected FCK rise SHALL shift synchronized SI into the RX shift register LSB and increment BITCNT modulo 8.
REQ-019 On the rise that wraps BITCNT 7->0, the block SHALL update RXDATA and pulse RXSTB and TXREQ in the same cycle.
REQ-020 TXDATA SHALL be sampled only at the launching fall; TXDATA SHALL be valid by then, which gives the user at least 1 CLK after TXREQ.
REQ-021 SO SHALL equal the TX shift register MSB; SO SHALL update no later than SYNC_STAGES+1 CLK after the FCK pin falls.
REQ-022 Supported FCK: each phase at least 2 CLK, which is the CLK/4 serial rate of the companion master.
REQ-023 SOE SHALL equal BUSY, where BUSY = state ACTIVE; in IDLE, SO SHALL drive 0.
REQ-024 FCK edges in IDLE, and FCK edges detected in the same cycle as the CSN fall, SHALL be ignored.
REQ-025 A CSN rise with BITCNT not equal to 0 SHALL pulse ABORT, discard the partial byte with no RXSTB, and return BITCNT to 0.
REQ-026 Frames of any length SHALL be supported; bytes SHALL stream back-to-back without a gap requirement.

Reset
REQ-027 While RSTN is low, all flops SHALL clear: state IDLE, BITCNT 0, SO 0, SOE 0, TXREQ/RXSTB/ABORT 0, RXDATA 0x00, BUSY 0, synchronizers at idle level (FCK 1, CSN 1, SI 0).
REQ-028 Reset asserted mid-frame SHALL abort silently with no ABORT pulse; after release the block SHALL wait for a fresh CSN fall.

Structure
REQ-029 Shared package serial_pkg SHALL hold BYTE_W=8, BITCNT width 3, and the IDLE/ACTIVE state encoding.
REQ-030 Sub-module sync_edge (N-flop synchronizer plus rise/fall detector, parameter SYNC_STAGES) SHALL be instantiated for FCK and CSN.

Verification
REQ-031 Single byte: CSN low, TXDATA=0xA5, master sends 0x3C at 4-CLK FCK -> SO bits 1,0,1,0,0,1,0,1; RXDATA=0x3C; one RXSTB and one TXREQ.
REQ-032 Streaming: 3 bytes 0x01,0x80,0xFF, with TXDATA changed to 0x11,0x22 within 1 CLK of each TXREQ -> RXDATA sequence 0x01,0x80,0xFF; SO carries 0xA5,0x11,0x22.
REQ-033 Abort: CSN rises after 5 FCK rises -> ABORT pulses once; no RXSTB; the next frame receives 0x5A correctly.
REQ-034 Idle noise: 16 FCK toggles with CSN high -> no RXSTB, no TXREQ, SOE stays 0, SO stays 0.
REQ-035 Reset mid-byte: RSTN low after 3 bits -> all outputs reach reset values immediately; no ABORT; the following frame is received correctly.
REQ-036 Timing: FCK phases of exactly 2 CLK with random FCK phase offset versus CLK -> master-side sampling of SO is error-free over 1000 random bytes.
